// File: rtl/psimd_operand_fetch_if.sv
// Handshake and register-file bus of the PSIMD operand fetch sequencer.
// The slave modport is the sequencer's view; the master modport is its environment.
interface psimd_operand_fetch_if #(
  parameter int unsigned REG_WIDTH  = 64,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned OP_WIDTH   = 4
);
  logic                  issue_valid;
  logic                  issue_ready;
  logic [OP_WIDTH-1:0]   issue_op;
  logic [1:0]            issue_nsrc;
  logic [ADDR_WIDTH-1:0] issue_rs1;
  logic [ADDR_WIDTH-1:0] issue_rs2;
  logic [ADDR_WIDTH-1:0] issue_rs3;

  logic                  rf_rd_en;
  logic [ADDR_WIDTH-1:0] rf_rd_addr;
  logic [REG_WIDTH-1:0]  rf_rd_data;

  logic                  wb_en;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [REG_WIDTH-1:0]  wb_data;

  logic                  out_valid;
  logic                  out_ready;
  logic [OP_WIDTH-1:0]   out_op;
  logic [REG_WIDTH-1:0]  data1;
  logic [REG_WIDTH-1:0]  data2;
  logic [REG_WIDTH-1:0]  data3;

  modport slave (
    input  issue_valid, issue_op, issue_nsrc, issue_rs1, issue_rs2, issue_rs3,
    input  rf_rd_data, wb_en, wb_addr, wb_data, out_ready,
    output issue_ready, rf_rd_en, rf_rd_addr, out_valid, out_op, data1, data2, data3
  );

  modport master (
    output issue_valid, issue_op, issue_nsrc, issue_rs1, issue_rs2, issue_rs3,
    output rf_rd_data, wb_en, wb_addr, wb_data, out_ready,
    input  issue_ready, rf_rd_en, rf_rd_addr, out_valid, out_op, data1, data2, data3
  );
endinterface

// File: rtl/psimd_operand_fetch.sv
// Operand fetch sequencer: reads up to three sources through one synchronous RF port,
// forwards writebacks that race a read, and presents the operands under valid/ready.
module psimd_operand_fetch #(
  parameter int unsigned REG_WIDTH  = 64,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned OP_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  psimd_operand_fetch_if.slave   bus_io
);

  typedef enum logic [2:0] {StIdle, StRd1, StRd2, StRd3, StCap, StValid} state_e;

  state_e                          state_q, state_d;
  logic [OP_WIDTH-1:0]             op_q;
  logic [1:0]                      nsrc_q;
  logic [2:0][ADDR_WIDTH-1:0]      rs_q;
  logic [2:0][REG_WIDTH-1:0]       data_q;
  logic                            fwd_hit_q;
  logic [REG_WIDTH-1:0]            fwd_data_q;

  logic                            accept;
  logic                            rd_en;
  logic [ADDR_WIDTH-1:0]           rd_addr;
  logic [2:0]                      cap_sel;
  logic [REG_WIDTH-1:0]            cap_data;
  logic                            wb_hit;

  assign accept   = bus_io.issue_valid && bus_io.issue_ready;
  assign wb_hit   = rd_en && bus_io.wb_en && (bus_io.wb_addr == rd_addr);
  assign cap_data = fwd_hit_q ? fwd_data_q : bus_io.rf_rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = (bus_io.issue_nsrc == 2'd0) ? StValid : StRd1;
      end
      StRd1:  state_d = (nsrc_q > 2'd1) ? StRd2 : StCap;
      StRd2:  state_d = (nsrc_q > 2'd2) ? StRd3 : StCap;
      StRd3:  state_d = StCap;
      StCap:  state_d = StValid;
      StValid: begin
        if (bus_io.out_ready) begin
          if (accept) state_d = (bus_io.issue_nsrc == 2'd0) ? StValid : StRd1;
          else        state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Operand k-1 lands on rf_rd_data during RDk; the last one lands during CAP.
  always_comb begin
    rd_en     = 1'b0;
    rd_addr   = '0;
    cap_sel   = 3'b000;
    bus_io.out_valid = 1'b0;
    unique case (state_q)
      StRd1: begin
        rd_en   = 1'b1;
        rd_addr = rs_q[0];
      end
      StRd2: begin
        rd_en   = 1'b1;
        rd_addr = rs_q[1];
        cap_sel = 3'b001;
      end
      StRd3: begin
        rd_en   = 1'b1;
        rd_addr = rs_q[2];
        cap_sel = 3'b010;
      end
      StCap:   cap_sel = 3'b001 << (nsrc_q - 2'd1);
      StValid: bus_io.out_valid = 1'b1;
      default: ;
    endcase
    bus_io.issue_ready = rst_n &&
                         ((state_q == StIdle) || ((state_q == StValid) && bus_io.out_ready));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      nsrc_q     <= '0;
      rs_q       <= '0;
      data_q     <= '0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      if (accept) begin
        op_q   <= bus_io.issue_op;
        nsrc_q <= bus_io.issue_nsrc;
        rs_q   <= {bus_io.issue_rs3, bus_io.issue_rs2, bus_io.issue_rs1};
        data_q <= '0;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (cap_sel[i]) data_q[i] <= cap_data;
        end
      end
      // The RF is read-before-write, so a write racing the read must be replayed here.
      fwd_hit_q <= wb_hit;
      if (wb_hit) fwd_data_q <= bus_io.wb_data;
    end
  end

  assign bus_io.rf_rd_en   = rd_en;
  assign bus_io.rf_rd_addr = rd_addr;
  assign bus_io.out_op     = op_q;
  assign bus_io.data1      = data_q[0];
  assign bus_io.data2      = data_q[1];
  assign bus_io.data3      = data_q[2];

endmodule

// File: tb/tb_psimd_operand_fetch.sv
// Scoreboard bench for psimd_operand_fetch: directed scenarios followed by random traffic,
// checked against a register-value reference model with a per-cycle monitor.
module tb_psimd_operand_fetch;
  localparam int unsigned RW = 64;
  localparam int unsigned AW = 5;
  localparam int unsigned OW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  psimd_operand_fetch_if #(.REG_WIDTH(RW), .ADDR_WIDTH(AW), .OP_WIDTH(OW)) bus ();

  psimd_operand_fetch #(.REG_WIDTH(RW), .ADDR_WIDTH(AW), .OP_WIDTH(OW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [63:0] rf_mem [32];
  logic [63:0] ref_rf [32];

  typedef struct {
    logic [3:0]       op;
    logic [2:0][63:0] d;
    int               vcyc;
  } exp_t;

  exp_t             q[$];
  exp_t             pexp;
  bit               pend = 1'b0;
  int               c0   = 0;
  logic [1:0]       pn;
  logic [2:0][4:0]  prs;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Register file environment: synchronous read, read-before-write, garbage when idle.
  always @(posedge clk) begin
    if (bus.rf_rd_en) bus.rf_rd_data <= rf_mem[bus.rf_rd_addr];
    else              bus.rf_rd_data <= {$urandom, $urandom};
    if (bus.wb_en) rf_mem[bus.wb_addr] <= bus.wb_data;
  end

  // Reference: operand k equals register rsk as it stands after the writes of the k-th
  // cycle following acceptance; it is presented nsrc+2 cycles (1 for nsrc=0) after acceptance.
  always @(negedge clk) begin : monitor
    int   k;
    bit   busy, er, ev, rdy;
    logic [4:0] ea;
    if (!rst_n) begin
      pend = 1'b0;
      q.delete();
      chk("rst_issue_ready", 64'(bus.issue_ready), 64'(0));
      chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_data1", bus.data1, 64'(0));
      if (bus.wb_en) ref_rf[bus.wb_addr] = bus.wb_data;
    end else begin
      k    = pend ? (cyc - c0) : 0;
      busy = pend && (k >= 1) && (k <= int'(pn) + 1);
      er   = pend && (k >= 1) && (k <= int'(pn));
      ea   = er ? prs[k-1] : 5'd0;
      ev   = (q.size() > 0) && (q[0].vcyc <= cyc);
      rdy  = !busy && (!ev || bus.out_ready);
      chk("out_valid", 64'(bus.out_valid), 64'(ev));
      chk("issue_ready", 64'(bus.issue_ready), 64'(rdy));
      chk("rf_rd_en", 64'(bus.rf_rd_en), 64'(er));
      chk("rf_rd_addr", 64'(bus.rf_rd_addr), 64'(ea));
      if (ev) begin
        chk("out_op", 64'(bus.out_op), 64'(q[0].op));
        chk("data1", bus.data1, q[0].d[0]);
        chk("data2", bus.data2, q[0].d[1]);
        chk("data3", bus.data3, q[0].d[2]);
        if (bus.out_ready) void'(q.pop_front());
      end
      if (bus.wb_en) ref_rf[bus.wb_addr] = bus.wb_data;
      if (er) begin
        pexp.d[k-1] = ref_rf[prs[k-1]];
        if (k == int'(pn)) begin
          pexp.vcyc = c0 + int'(pn) + 2;
          q.push_back(pexp);
        end
      end
      if (pend && (k == int'(pn) + 1)) pend = 1'b0;
      if (bus.issue_valid && rdy) begin
        pexp.op = bus.issue_op;
        pexp.d  = '0;
        if (bus.issue_nsrc == 2'd0) begin
          pexp.vcyc = cyc + 1;
          q.push_back(pexp);
        end else begin
          pend = 1'b1;
          c0   = cyc;
          pn   = bus.issue_nsrc;
          prs  = {bus.issue_rs3, bus.issue_rs2, bus.issue_rs1};
        end
      end
    end
  end

  // Returns at #1 after the accepting edge, i.e. inside the RD1 cycle.
  task automatic do_issue(input logic [3:0] op, input logic [1:0] n,
                          input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3);
    int t = 0;
    bus.issue_op    = op;
    bus.issue_nsrc  = n;
    bus.issue_rs1   = a1;
    bus.issue_rs2   = a2;
    bus.issue_rs3   = a3;
    bus.issue_valid = 1'b1;
    @(negedge clk);
    while (!bus.issue_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.issue_ready) chk("issue_accept_timeout", 64'(bus.issue_ready), 64'(1));
    @(posedge clk);
    #1;
    bus.issue_valid = 1'b0;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] a, input logic [63:0] d);
    bus.wb_en   = en;
    bus.wb_addr = a;
    bus.wb_data = d;
  endtask

  initial begin
    bit stall;
    int t;
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = 64'(i) * 64'h1111_1111_1111_1111;
      ref_rf[i] = rf_mem[i];
    end
    bus.issue_valid = 1'b0;
    bus.issue_op    = '0;
    bus.issue_nsrc  = '0;
    bus.issue_rs1   = '0;
    bus.issue_rs2   = '0;
    bus.issue_rs3   = '0;
    bus.out_ready   = 1'b1;
    set_wb(1'b0, 5'd0, 64'd0);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("post_rst_data2", bus.data2, 64'(0));
    chk("post_rst_op", 64'(bus.out_op), 64'(0));

    // Three reads, no writes.
    do_issue(4'h3, 2'd3, 5'd1, 5'd2, 5'd3);
    repeat (6) @(posedge clk);
    #1;

    // nsrc=1 then nsrc=0 back-to-back.
    do_issue(4'h5, 2'd1, 5'd5, 5'd0, 5'd0);
    do_issue(4'h6, 2'd0, 5'd9, 5'd9, 5'd9);
    repeat (3) @(posedge clk);
    #1;

    // Write to rs2 during RD2 is forwarded.
    do_issue(4'h7, 2'd3, 5'd1, 5'd7, 5'd2);
    @(posedge clk);
    #1 set_wb(1'b1, 5'd7, 64'hDEAD_BEEF_0000_0001);
    @(posedge clk);
    #1 set_wb(1'b0, 5'd0, 64'd0);
    repeat (6) @(posedge clk);
    #1;

    // Same kind of write one cycle later (capture cycle) must not be forwarded.
    do_issue(4'h8, 2'd2, 5'd3, 5'd7, 5'd1);
    repeat (2) @(posedge clk);
    #1 set_wb(1'b1, 5'd7, 64'hDEAD_BEEF_0000_0002);
    @(posedge clk);
    #1 set_wb(1'b0, 5'd0, 64'd0);
    repeat (4) @(posedge clk);
    #1;

    // Backpressure with toggling RF/writeback inputs and a waiting next instruction.
    bus.out_ready = 1'b0;
    do_issue(4'h9, 2'd2, 5'd1, 5'd2, 5'd0);
    bus.issue_valid = 1'b1;
    bus.issue_op    = 4'hE;
    bus.issue_nsrc  = 2'd1;
    bus.issue_rs1   = 5'd3;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1 set_wb(1'($urandom), 5'($urandom_range(0, 7)), {$urandom, $urandom});
    end
    set_wb(1'b0, 5'd0, 64'd0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.issue_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Same register three times with a write only in RD1.
    do_issue(4'hA, 2'd3, 5'd4, 5'd4, 5'd4);
    set_wb(1'b1, 5'd4, 64'h0123_4567_89AB_CDEF);
    @(posedge clk);
    #1 set_wb(1'b0, 5'd0, 64'd0);
    repeat (6) @(posedge clk);
    #1;

    // Asynchronous reset during RD2.
    do_issue(4'hB, 2'd3, 5'd1, 5'd2, 5'd3);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_rd_en", 64'(bus.rf_rd_en), 64'(0));
    chk("async_rst_rd_addr", 64'(bus.rf_rd_addr), 64'(0));
    chk("async_rst_op", 64'(bus.out_op), 64'(0));
    chk("async_rst_ready", 64'(bus.issue_ready), 64'(0));
    chk("async_rst_data3", bus.data3, 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_issue(4'hC, 2'd2, 5'd5, 5'd6, 5'd0);
    repeat (6) @(posedge clk);
    #1;

    // Random traffic with stall phases and racing writebacks.
    stall = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (i % 50 == 0) stall = ($urandom_range(0, 2) == 0);
      bus.out_ready   = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
      bus.issue_valid = 1'($urandom);
      bus.issue_op    = 4'($urandom);
      bus.issue_nsrc  = 2'($urandom);
      bus.issue_rs1   = 5'($urandom_range(0, 7));
      bus.issue_rs2   = 5'($urandom_range(0, 7));
      bus.issue_rs3   = 5'($urandom_range(0, 7));
      set_wb(1'($urandom), 5'($urandom_range(0, 7)), {$urandom, $urandom});
    end

    bus.issue_valid = 1'b0;
    bus.out_ready   = 1'b1;
    set_wb(1'b0, 5'd0, 64'd0);
    t = 0;
    while ((q.size() != 0 || pend) && t < 50) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    chk("drain_outstanding", 64'(q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/psimd_operand_fetch.md
# psimd_operand_fetch

Operand fetch sequencer directly upstream of the PSIMD lane splitter. It accepts one issued PSIMD instruction at a time and reads up to three 64-bit source registers through a single synchronous register-file read port. Writebacks that race a read are forwarded. It then presents the three packed operands (`data1`/`data2`/`data3`) plus the opcode to the splitter/DLFloat datapath under a valid/ready handshake.

## Interface
- `REG_WIDTH`, 64: operand width; must be 64, four 16-bit DLFloat lanes.
- `ADDR_WIDTH`, 5: register-file address width.
- `OP_WIDTH`, 4: opcode width, passed through unchanged.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `issue_valid`  in  1  instruction offered.
- `issue_ready`  out  1  instruction accepted when `issue_valid && issue_ready` at a rising edge.
- `issue_op`  in  OP_WIDTH  opcode.
- `issue_nsrc`  in  2  number of source operands to read, 0..3.
- `issue_rs1`, `issue_rs2`, `issue_rs3`  in  ADDR_WIDTH  source register addresses.
- `rf_rd_en`  out  1  register-file read strobe.
- `rf_rd_addr`  out  ADDR_WIDTH  read address.
- `rf_rd_data`  in  REG_WIDTH  read data; valid the cycle after `rf_rd_en`; read-before-write.
- `wb_en`  in  1  register-file write this cycle.
- `wb_addr`  in  ADDR_WIDTH  write address.
- `wb_data`  in  REG_WIDTH  write data.
- `out_valid`  out  1  operands valid.
- `out_ready`  in  1  consumer accepts.
- `out_op`  out  OP_WIDTH  latched opcode.
- `data1`, `data2`, `data3`  out  REG_WIDTH  operands from rs1/rs2/rs3.

## Operation
- States: IDLE, RD1, RD2, RD3, CAP, VALID.
- IDLE: `issue_ready=1`. On acceptance, latch op, nsrc and rs1..3, and clear `data1..3` to 0.
  - nsrc=0: go to VALID.
  - Otherwise: go to RD1.
- RDk (k=1..3): `rf_rd_en=1`, `rf_rd_addr=rsk`.
  - The data returned for operand k-1 is captured in this cycle.
  - Next state is RD(k+1) if k<nsrc, else CAP.
- CAP: captures the last operand and goes to VALID; `rf_rd_en=0`.
- VALID: `out_valid=1`. `data1..3` and `out_op` are held stable until `out_ready`.
  - On handshake, go to IDLE.
  - If `issue_valid` is also high in that cycle, accept the next instruction and go directly to RD1 (or stay in VALID if its nsrc=0).
- `issue_ready = (state==IDLE) || (state==VALID && out_ready)`. It is 0 in all other states.
- Operands beyond nsrc remain 0.
- Forwarding:
  - If `wb_en && wb_addr==rsk` in the RDk cycle, the RF returns stale data. Register `wb_data` and a hit flag, and capture the registered data instead of `rf_rd_data`.
  - A write in the capture cycle is not forwarded; it is younger than the read.
  - If several operands share an address, each one forwards independently.
- `rf_rd_en` and `rf_rd_addr` are combinational from state; `rf_rd_addr=0` when `rf_rd_en=0`.

## Timing
- Reset (`rst_n` low, asynchronous, any state):
  - state goes to IDLE;
  - `out_valid=0`, `data1..3=0`, `out_op=0`, `rf_rd_en=0`, `rf_rd_addr=0`, forward flags cleared;
  - `issue_ready=0` while `rst_n` is low, 1 from the first cycle after deassertion.
- A reset mid-fetch discards the instruction; no `out_valid` is produced for it.
- Latency from the accepting edge to `out_valid` high: nsrc+2 cycles for nsrc 1..3, and 1 cycle for nsrc=0.
- Throughput with `out_ready` held high: one instruction every nsrc+2 cycles (every cycle for nsrc=0).
- Backpressure: while `out_valid && !out_ready`, outputs are frozen and `issue_ready=0`. Input changes on `rf_rd_data` and `wb_*` are ignored.
- `issue_*` fields are sampled only on the accepting edge.

## Test plan
- nsrc=3, rs1/2/3=1/2/3, RF holds 0x1111…, 0x2222…, 0x3333…:
  - `rf_rd_en` is high for 3 cycles with addresses 1, 2, 3;
  - `out_valid` rises 5 cycles after acceptance with `data1..3` = those values.
- nsrc=1 then nsrc=0 back-to-back with `out_ready`=1:
  - the first instruction gives `data1` = RF[rs1] and `data2`=`data3`=0, valid at +3;
  - the second is accepted in the handshake cycle and is valid on the next cycle with all operands 0.
- Forward: rs2=7, with `wb_en`=1, `wb_addr`=7, `wb_data`=0xDEAD_BEEF_0000_0001 in the RD2 cycle → `data2`=0xDEAD_BEEF_0000_0001, not the stale RF[7]. The same write in the CAP/capture cycle → stale RF[7].
- Backpressure: hold `out_ready`=0 for 10 cycles while toggling `rf_rd_data` and `wb_*` → `data1..3`/`out_op` are unchanged and `issue_ready`=0 throughout. Releasing gives a single handshake.
- Reset asserted in RD2 → outputs go to 0 immediately (asynchronously). After release: IDLE, `issue_ready`=1, and the next instruction completes normally.
- rs1=rs2=rs3=4 with a write to r4 in the RD1 cycle only → `data1`=`wb_data`, while `data2`/`data3` come from `rf_rd_data` (the post-write RF value).
